// File: rtl/cpu_pkg.sv
// Shared fetch-side types and widths for the 16-bit instruction fetch path.
package cpu_pkg;

  localparam int INST_WIDTH     = 16;
  localparam int MEM_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_HI = 2'd1,
    FETCH_LO = 2'd2,
    HOLD     = 2'd3
  } fetch_state_t;

  // Even-address byte is the high half of the instruction word.
  function automatic logic [INST_WIDTH-1:0] pack_inst(
    input logic [MEM_DATA_WIDTH-1:0] hi,
    input logic [MEM_DATA_WIDTH-1:0] lo
  );
    return {hi, lo};
  endfunction

endpackage

// File: rtl/fetch_inst_slot.sv
// One instruction holding register: {inst, pc, valid}, load wins over clear.
module fetch_inst_slot
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [INST_WIDTH-1:0] inst_in,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst  <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (load) begin
      inst  <= inst_in;
      pc    <= pc_in;
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Two-beat byte fetch of 16-bit instructions with PC ownership and jump redirect.
// Optional PREFETCH_BUF_EN adds a second slot so fetching continues while the decoder stalls.
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      mem_req_out,
  output logic [ADDR_WIDTH-1:0]     mem_addr_out,
  input  logic                      mem_ack_in,
  input  logic [MEM_DATA_WIDTH-1:0] mem_data_in,
  output logic [INST_WIDTH-1:0]     inst_out,
  output logic                      inst_valid_out,
  input  logic                      inst_ready_in,
  output logic [ADDR_WIDTH-1:0]     pc_out,
  input  logic                      jump_en_in,
  input  logic [ADDR_WIDTH-1:0]     jump_addr_in,
  input  logic                      halt_in
);

  localparam logic [ADDR_WIDTH-1:0] LSB_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = {{(ADDR_WIDTH-2){1'b0}}, 2'b10};
  localparam logic [ADDR_WIDTH-1:0] START_PC = RESET_PC & ~LSB_ONE;

  fetch_state_t                state_r;
  logic                        kill_r;
  logic                        req_r;
  logic [ADDR_WIDTH-1:0]       addr_r;
  logic [ADDR_WIDTH-1:0]       pc_r;
  logic [MEM_DATA_WIDTH-1:0]   hi_r;

  logic                        beat_done_s;
  logic                        lo_done_s;
  logic                        accept_s;
  logic                        go_s;
  logic                        full_next_s;
  logic [ADDR_WIDTH-1:0]       jump_target_s;
  logic [INST_WIDTH-1:0]       new_inst_s;

  logic                        out_load_s;
  logic                        out_clear_s;
  logic [INST_WIDTH-1:0]       out_inst_in_s;
  logic [ADDR_WIDTH-1:0]       out_pc_in_s;
  logic                        out_valid_s;
  logic [INST_WIDTH-1:0]       out_inst_s;
  logic [ADDR_WIDTH-1:0]       out_pc_s;

  assign beat_done_s   = req_r & mem_ack_in;
  // A completed low beat only delivers when it was neither killed nor overtaken by a jump.
  assign lo_done_s     = beat_done_s & (state_r == FETCH_LO) & ~kill_r & ~jump_en_in;
  assign accept_s      = out_valid_s & inst_ready_in;
  assign jump_target_s = jump_addr_in & ~LSB_ONE;
  assign new_inst_s    = pack_inst(hi_r, mem_data_in);
  assign go_s          = ~halt_in & ~full_next_s;

`ifdef PREFETCH_BUF_EN
  logic                  slot_valid_s;
  logic [INST_WIDTH-1:0] slot_inst_s;
  logic [ADDR_WIDTH-1:0] slot_pc_s;
  logic                  slot_load_s;
  logic                  slot_clear_s;
  logic                  slot_to_out_s;
  logic                  new_to_out_s;

  // Route a fresh instruction to inst_out or the prefetch slot; shift the slot forward on accept.
  always_comb begin
    slot_to_out_s = accept_s & slot_valid_s & ~jump_en_in;
    new_to_out_s  = lo_done_s & (~out_valid_s | (accept_s & ~slot_valid_s));
    out_load_s    = slot_to_out_s | new_to_out_s;
    out_clear_s   = jump_en_in | accept_s;
    if (slot_to_out_s) begin
      out_inst_in_s = slot_inst_s;
      out_pc_in_s   = slot_pc_s;
    end else begin
      out_inst_in_s = new_inst_s;
      out_pc_in_s   = pc_r;
    end
    slot_load_s   = lo_done_s & ~new_to_out_s;
    slot_clear_s  = jump_en_in | slot_to_out_s;
    full_next_s   = (out_load_s | (out_valid_s & ~out_clear_s)) &
                    (slot_load_s | (slot_valid_s & ~slot_clear_s));
  end

  fetch_inst_slot #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_prefetch_slot (
    .clk     (clk),
    .rst     (rst),
    .load    (slot_load_s),
    .clear   (slot_clear_s),
    .inst_in (new_inst_s),
    .pc_in   (pc_r),
    .inst    (slot_inst_s),
    .pc      (slot_pc_s),
    .valid   (slot_valid_s)
  );
`else
  // Single slot: a delivered instruction blocks further fetching until it is accepted.
  always_comb begin
    out_load_s    = lo_done_s;
    out_clear_s   = jump_en_in | accept_s;
    out_inst_in_s = new_inst_s;
    out_pc_in_s   = pc_r;
    full_next_s   = out_load_s | (out_valid_s & ~out_clear_s);
  end
`endif

  fetch_inst_slot #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_out_slot (
    .clk     (clk),
    .rst     (rst),
    .load    (out_load_s),
    .clear   (out_clear_s),
    .inst_in (out_inst_in_s),
    .pc_in   (out_pc_in_s),
    .inst    (out_inst_s),
    .pc      (out_pc_s),
    .valid   (out_valid_s)
  );

  // Fetch FSM. A jump with a beat in flight keeps req/addr stable and only arms the kill flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      kill_r  <= 1'b0;
      req_r   <= 1'b0;
      addr_r  <= START_PC;
      pc_r    <= START_PC;
      hi_r    <= '0;
    end else if (jump_en_in) begin
      pc_r <= jump_target_s;
      if (req_r && !mem_ack_in) begin
        kill_r <= 1'b1;
      end else begin
        kill_r  <= 1'b0;
        state_r <= go_s ? FETCH_HI : IDLE;
        req_r   <= go_s;
        addr_r  <= jump_target_s;
      end
    end else if (kill_r) begin
      if (beat_done_s) begin
        kill_r  <= 1'b0;
        state_r <= go_s ? FETCH_HI : IDLE;
        req_r   <= go_s;
        addr_r  <= pc_r;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (go_s) begin
            state_r <= FETCH_HI;
            req_r   <= 1'b1;
            addr_r  <= pc_r;
          end
        end
        FETCH_HI: begin
          if (beat_done_s) begin
            hi_r    <= mem_data_in;
            addr_r  <= pc_r | LSB_ONE;
            state_r <= FETCH_LO;
          end
        end
        FETCH_LO: begin
          if (beat_done_s) begin
            pc_r <= pc_r + PC_STEP;
            if (go_s) begin
              state_r <= FETCH_HI;
              req_r   <= 1'b1;
              addr_r  <= pc_r + PC_STEP;
            end else begin
              req_r   <= 1'b0;
              state_r <= full_next_s ? HOLD : IDLE;
            end
          end
        end
        HOLD: begin
          if (go_s) begin
            state_r <= FETCH_HI;
            req_r   <= 1'b1;
            addr_r  <= pc_r;
          end else if (!full_next_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_out    = req_r;
  assign mem_addr_out   = addr_r;
  assign inst_out       = out_inst_s;
  assign pc_out         = out_pc_s;
  assign inst_valid_out = out_valid_s;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: vector table for steady fetch, hand sequences for corner cases.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [15:0] inst;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [15:0] pc;
  logic        jump_en = 1'b0;
  logic [15:0] jump_addr = 16'h0000;
  logic        halt = 1'b0;
  logic [3:0]  mem_wait = 4'd0;
  logic [3:0]  waited;

  logic        mem_req2;
  logic [15:0] mem_addr2;
  logic        mem_ack2;
  logic [7:0]  mem_data2;
  logic [15:0] inst2;
  logic        inst_valid2;
  logic [15:0] pc2;
  logic        ready2 = 1'b1;
  logic        jump_en2 = 1'b0;
  logic [15:0] jump_addr2 = 16'h0000;
  logic        halt2 = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [15:0] addr2_q[$];
  logic [31:0] deliv2_q[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'h0000: return 8'h12;
      16'h0001: return 8'h34;
      16'h0002: return 8'h56;
      16'h0003: return 8'h78;
      default:  return a[7:0] + 8'h30;
    endcase
  endfunction

  assign mem_ack   = mem_req && (waited >= mem_wait);
  assign mem_data  = mem_byte(mem_addr);
  assign mem_ack2  = mem_req2;
  assign mem_data2 = mem_byte(mem_addr2);

  always @(posedge clk) begin
    if (rst) waited <= 4'd0;
    else if (mem_req && !mem_ack) waited <= waited + 4'd1;
    else waited <= 4'd0;
  end

  always @(posedge clk) begin
    if (!rst && mem_req2 && mem_ack2 && addr2_q.size() < 3) addr2_q.push_back(mem_addr2);
    if (!rst && inst_valid2 && ready2 && deliv2_q.size() < 2) deliv2_q.push_back({inst2, pc2});
  end

  inst_fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .mem_req_out(mem_req), .mem_addr_out(mem_addr), .mem_ack_in(mem_ack), .mem_data_in(mem_data),
    .inst_out(inst), .inst_valid_out(inst_valid), .inst_ready_in(inst_ready), .pc_out(pc),
    .jump_en_in(jump_en), .jump_addr_in(jump_addr), .halt_in(halt)
  );

  inst_fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'hFFFE)) dut_wrap (
    .clk(clk), .rst(rst),
    .mem_req_out(mem_req2), .mem_addr_out(mem_addr2), .mem_ack_in(mem_ack2), .mem_data_in(mem_data2),
    .inst_out(inst2), .inst_valid_out(inst_valid2), .inst_ready_in(ready2), .pc_out(pc2),
    .jump_en_in(jump_en2), .jump_addr_in(jump_addr2), .halt_in(halt2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ready;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_inst;
    logic [15:0] e_pc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int held;
    vecs[0] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 16'h0001, 1'b1, 16'h1234, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 16'h0002, 1'b0, 16'h1234, 16'h0000};
    vecs[4] = '{1'b1, 1'b1, 16'h0003, 1'b0, 16'h1234, 16'h0000};
    vecs[5] = '{1'b1, 1'b0, 16'h0003, 1'b1, 16'h5678, 16'h0002};
    vecs[6] = '{1'b0, 1'b0, 16'h0003, 1'b1, 16'h5678, 16'h0002};
    vecs[7] = '{1'b1, 1'b1, 16'h0004, 1'b0, 16'h5678, 16'h0002};
    vecs[8] = '{1'b1, 1'b1, 16'h0005, 1'b0, 16'h5678, 16'h0002};
    vecs[9] = '{1'b0, 1'b0, 16'h0005, 1'b1, 16'h3435, 16'h0004};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", {16'd0, mem_addr}, 32'h0000);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", {16'd0, inst}, 32'h0000);
    check("rst_pc", {16'd0, pc}, 32'h0000);
    rst = 1'b0;

    // steady fetch, 0-wait memory
    for (int i = 0; i < 10; i++) begin
      inst_ready = vecs[i].ready;
      @(negedge clk);
      check($sformatf("v%0d_req", i), {31'd0, mem_req}, {31'd0, vecs[i].e_req});
      check($sformatf("v%0d_addr", i), {16'd0, mem_addr}, {16'd0, vecs[i].e_addr});
      check($sformatf("v%0d_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].e_valid});
      check($sformatf("v%0d_inst", i), {16'd0, inst}, {16'd0, vecs[i].e_inst});
      check($sformatf("v%0d_pc", i), {16'd0, pc}, {16'd0, vecs[i].e_pc});
    end

    // decoder stall: outputs held, no memory traffic
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, inst_valid}, 32'd1);
      check("stall_inst", {16'd0, inst}, 32'h3435);
      check("stall_pc", {16'd0, pc}, 32'h0004);
      check("stall_req", {31'd0, mem_req}, 32'd0);
    end

    // jump during a slow low beat
    inst_ready = 1'b1;
    mem_wait = 4'd3;
    for (int i = 0; i < 40 && !(mem_req && mem_addr == 16'h0007); i++) @(negedge clk);
    check("reach_lo_beat", {31'd0, (mem_req && mem_addr == 16'h0007)}, 32'd1);
    jump_en = 1'b1;
    jump_addr = 16'h0041;
    @(negedge clk);
    jump_en = 1'b0;
    held = 0;
    while (held < 10 && mem_req && mem_addr == 16'h0007) begin
      held++;
      check("jump_no_stale_valid", {31'd0, inst_valid}, 32'd0);
      @(negedge clk);
    end
    check("jump_hold_cycles", held, 3);
    check("jump_new_req", {31'd0, mem_req}, 32'd1);
    check("jump_new_addr", {16'd0, mem_addr}, 32'h0040);
    check("jump_valid_low", {31'd0, inst_valid}, 32'd0);
    mem_wait = 4'd0;
    for (int i = 0; i < 40 && !inst_valid; i++) @(negedge clk);
    check("jump_inst", {16'd0, inst}, 32'h7071);
    check("jump_pc", {16'd0, pc}, 32'h0040);

    // halt during FETCH_HI: instruction still delivered, then idle
    for (int i = 0; i < 40 && !(mem_req && mem_addr == 16'h0042); i++) @(negedge clk);
    check("reach_hi_0042", {31'd0, (mem_req && mem_addr == 16'h0042)}, 32'd1);
    halt = 1'b1;
    for (int i = 0; i < 40 && !inst_valid; i++) @(negedge clk);
    check("halt_inst", {16'd0, inst}, 32'h7273);
    check("halt_pc", {16'd0, pc}, 32'h0042);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("halt_idle_req", {31'd0, mem_req}, 32'd0);
      check("halt_idle_valid", {31'd0, inst_valid}, 32'd0);
    end
    halt = 1'b0;
    @(negedge clk);
    check("unhalt_req", {31'd0, mem_req}, 32'd1);
    check("unhalt_addr", {16'd0, mem_addr}, 32'h0044);

    // asynchronous reset in the middle of a low beat
    for (int i = 0; i < 40 && !(mem_req && mem_addr == 16'h0045); i++) @(negedge clk);
    check("reach_lo_0045", {31'd0, (mem_req && mem_addr == 16'h0045)}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_req", {31'd0, mem_req}, 32'd0);
    check("arst_addr", {16'd0, mem_addr}, 32'h0000);
    check("arst_valid", {31'd0, inst_valid}, 32'd0);
    check("arst_inst", {16'd0, inst}, 32'h0000);
    check("arst_pc", {16'd0, pc}, 32'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("refetch_req", {31'd0, mem_req}, 32'd1);
    check("refetch_addr", {16'd0, mem_addr}, 32'h0000);
    for (int i = 0; i < 40 && !inst_valid; i++) @(negedge clk);
    check("refetch_inst", {16'd0, inst}, 32'h1234);
    check("refetch_pc", {16'd0, pc}, 32'h0000);

    // wrap-around instance
    check("wrap_addr_count", addr2_q.size(), 3);
    if (addr2_q.size() >= 3) begin
      check("wrap_addr0", {16'd0, addr2_q[0]}, 32'hFFFE);
      check("wrap_addr1", {16'd0, addr2_q[1]}, 32'hFFFF);
      check("wrap_addr2", {16'd0, addr2_q[2]}, 32'h0000);
    end
    check("wrap_deliv_count", deliv2_q.size(), 2);
    if (deliv2_q.size() >= 2) begin
      check("wrap_deliv0", deliv2_q[0], 32'h2E2F_FFFE);
      check("wrap_deliv1", deliv2_q[1], 32'h1234_0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
